// File: rtl/move_feeder.sv
// rtl/move_feeder.sv - ASCII move-list parser feeding the dial solver one paced move at a time
//
// Optional feature macro: MOVE_FEEDER_STATS_EN (builds the moves_sent counter).
//
// Ports:
//   clk            in   1            sole clock, posedge
//   rst            in   1            asynchronous active-low reset
//   in_valid       in   1            in_data holds a byte
//   in_ready       out  1            byte accepted this cycle when in_valid && in_ready
//   in_data        in   8            ASCII byte
//   valid          out  1            one-cycle move pulse to the solver
//   step_direction out  1            1 = R (up), 0 = L (down)
//   step_count     out  COUNT_WIDTH  move magnitude
//   error          out  1            sticky parse error
//   moves_sent     out  16           number of valid pulses (0 when stats disabled)
module move_feeder #(
  parameter int COUNT_WIDTH = 10,
  parameter int GAP         = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  output logic                   valid,
  output logic                   step_direction,
  output logic [COUNT_WIDTH-1:0] step_count,
  output logic                   error,
  output logic [15:0]            moves_sent
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_NUM  = 3'd1;
  localparam logic [2:0] S_EMIT = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_SKIP = 3'd4;

  // Wide enough to hold the largest move plus the idle gap.
  localparam int WAIT_W = $clog2((2 ** COUNT_WIDTH) + GAP + 1);

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  logic [2:0]             state;
  logic [COUNT_WIDTH-1:0] acc;
  logic                   have_digit;
  logic                   dir;
  logic [WAIT_W-1:0]      wait_cnt;

  logic                   fire;
  logic                   is_digit;
  logic [COUNT_WIDTH+3:0] acc_wide;
  logic [COUNT_WIDTH+3:0] acc_next;
  logic                   acc_ovf;
  logic [WAIT_W-1:0]      wait_load;

  assign fire     = in_valid && in_ready;
  assign is_digit = (in_data >= CH_0) && (in_data <= CH_9);

  // acc*10 + digit as (acc<<3)+(acc<<1)+d; four guard bits cannot overflow.
  assign acc_wide = {4'b0000, acc};
  assign acc_next = (acc_wide << 3) + (acc_wide << 1) + {{COUNT_WIDTH{1'b0}}, in_data[3:0]};
  assign acc_ovf  = |acc_next[COUNT_WIDTH+3:COUNT_WIDTH];

  assign wait_load = WAIT_W'(acc) + WAIT_W'(GAP);

  // Handshake is decoded purely from state so upstream can never see a combinational loop.
  assign in_ready = (state == S_IDLE) || (state == S_NUM) || (state == S_SKIP);
  assign valid    = (state == S_EMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      acc            <= '0;
      have_digit     <= 1'b0;
      dir            <= 1'b0;
      wait_cnt       <= '0;
      step_direction <= 1'b0;
      step_count     <= '0;
      error          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fire) begin
            if (in_data == CH_L || in_data == CH_R) begin
              dir        <= (in_data == CH_R);
              acc        <= '0;
              have_digit <= 1'b0;
              state      <= S_NUM;
            end else if (in_data != CH_LF && in_data != CH_CR) begin
              error <= 1'b1;
              state <= S_SKIP;
            end
          end
        end
        S_NUM: begin
          if (fire) begin
            if (is_digit) begin
              if (acc_ovf) begin
                error <= 1'b1;
                state <= S_SKIP;
              end else begin
                acc        <= acc_next[COUNT_WIDTH-1:0];
                have_digit <= 1'b1;
              end
            end else if (in_data == CH_LF) begin
              if (have_digit) begin
                // Outputs are loaded here so they are already stable in the EMIT cycle.
                step_count     <= acc;
                step_direction <= dir;
                state          <= S_EMIT;
              end else begin
                error <= 1'b1;
                state <= S_IDLE;
              end
            end else if (in_data != CH_CR) begin
              error <= 1'b1;
              state <= S_SKIP;
            end
          end
        end
        S_EMIT: begin
          if (wait_load == '0) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_load;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Loaded with K, WAIT lasts exactly K cycles.
          if (wait_cnt == WAIT_W'(1)) begin
            state <= S_IDLE;
          end
          wait_cnt <= wait_cnt - WAIT_W'(1);
        end
        S_SKIP: begin
          if (fire && in_data == CH_LF) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MOVE_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      moves_sent <= 16'h0000;
    end else if (state == S_EMIT && moves_sent != 16'hFFFF) begin
      moves_sent <= moves_sent + 16'h0001;
    end
  end
`else
  assign moves_sent = 16'h0000;
`endif

endmodule

// File: tb/tb_move_feeder.sv
// tb/tb_move_feeder.sv - scoreboard bench for move_feeder
module tb_move_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       valid;
  logic       step_direction;
  logic [9:0] step_count;
  logic       error;
  logic [15:0] moves_sent;

`ifdef MOVE_FEEDER_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  move_feeder #(.COUNT_WIDTH(10), .GAP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .valid(valid), .step_direction(step_direction), .step_count(step_count),
    .error(error), .moves_sent(moves_sent)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       dir;
    logic [9:0] cnt;
  } move_t;

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    run = 0;
  move_t sb[$];
  int    vtimes[$];
  int    runs[$];
  move_t exp_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard consumer: every valid pulse pops one expected move.
  always @(negedge clk) begin
    if (rst) begin
      if (valid) begin
        vtimes.push_back(cyc);
        check("valid_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_m = sb.pop_front();
          check("step_direction", step_direction, exp_m.dir);
          check("step_count", step_count, exp_m.cnt);
        end
      end
      if (!in_ready) run++;
      else if (run != 0) begin
        runs.push_back(run);
        run = 0;
      end
    end
  end

  task automatic send_str(input string s, input bit bubbles);
    int n;
    bit timed_out;
    timed_out = 0;
    for (int i = 0; i < s.len(); i++) begin
      if (bubbles && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = s[i];
      n = 0;
      while (!in_ready && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 3000) timed_out = 1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("ready_timeout", timed_out, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < 5000, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_logs();
    runs.delete();
    vtimes.delete();
    run = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_dir"}, step_direction, 0);
    check({tag, "_count"}, step_count, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_moves"}, moves_sent, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    clear_logs();

    // Single move: R48, stall 1+48+1
    sb.push_back('{dir: 1'b1, cnt: 10'd48});
    send_str("R48\n", 0);
    wait_idle();
    check("t1_pulses", vtimes.size(), 1);
    check("t1_runs", runs.size(), 1);
    check("t1_stall", runs.size() > 0 ? runs[0] : -1, 50);
    check("t1_error", error, 0);

    // Back-to-back moves: spacing 73
    do_reset();
    sb.push_back('{dir: 1'b0, cnt: 10'd68});
    sb.push_back('{dir: 1'b1, cnt: 10'd5});
    send_str("L68\nR5\n", 0);
    wait_idle();
    check("t2_pulses", vtimes.size(), 2);
    check("t2_spacing", vtimes.size() == 2 ? vtimes[1] - vtimes[0] : -1, 73);
    check("t2_stall0", runs.size() > 0 ? runs[0] : -1, 70);
    check("t2_stall1", runs.size() > 1 ? runs[1] : -1, 7);
    check("t2_moves", moves_sent, STATS ? 2 : 0);

    // Overflow: 1024 does not fit in 10 bits
    do_reset();
    send_str("L1024\n", 0);
    wait_idle();
    check("t3_error_ovf", error, 1);
    check("t3_no_pulse", vtimes.size(), 0);
    sb.push_back('{dir: 1'b1, cnt: 10'd1});
    send_str("R1\n", 0);
    wait_idle();
    check("t3_pulses", vtimes.size(), 1);
    check("t3_error_sticky", error, 1);

    // Blank lines and zero move
    do_reset();
    sb.push_back('{dir: 1'b0, cnt: 10'd0});
    send_str("\015\n\nL0\015\n", 0);
    wait_idle();
    check("t4_pulses", vtimes.size(), 1);
    check("t4_stall", runs.size() > 0 ? runs[0] : -1, 2);
    check("t4_error", error, 0);

    // Malformed lines, upstream bubbles
    do_reset();
    sb.push_back('{dir: 1'b1, cnt: 10'd7});
    send_str("X12\nL\nR7\n", 1);
    wait_idle();
    check("t5_error", error, 1);
    check("t5_pulses", vtimes.size(), 1);
    check("t5_moves", moves_sent, STATS ? 1 : 0);
    check("t5_hold_count", step_count, 7);
    check("t5_hold_dir", step_direction, 1);

    // Reset mid-line
    send_str("R12", 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midreset");
    rst = 1'b1;
    @(negedge clk);
    clear_logs();
    sb.push_back('{dir: 1'b0, cnt: 10'd3});
    send_str("L3\n", 0);
    wait_idle();
    check("t6_pulses", vtimes.size(), 1);
    check("t6_error", error, 0);
    check("t6_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
